// File: rtl/sram_controller_if.sv
// -----------------------------------------------------------------------------
// sram_controller_if
//
// Pipeline-side bus between the MEM stage and the SRAM controller.
//
// Signals:
//   wr_en       store request, held high until ready
//   rd_en       load request, held high until ready
//   address     32-bit byte address of the access
//   write_data  32-bit store data
//   read_data   32-bit registered load result
//   ready       access complete or nothing pending (pipeline freeze = ~ready)
//
// Modports:
//   master  pipeline side (drives requests, receives results)
//   slave   controller side
// -----------------------------------------------------------------------------
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en,
    output rd_en,
    output address,
    output write_data,
    input  read_data,
    input  ready
  );

  modport slave (
    input  wr_en,
    input  rd_en,
    input  address,
    input  write_data,
    output read_data,
    output ready
  );
endinterface

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//
// Bridges 32-bit pipeline loads/stores onto an asynchronous 16-bit SRAM.
// Each access is split into a LOW phase (even half-word, data bits [15:0]) and
// a HIGH phase (odd half-word, data bits [31:16]), followed by a one-cycle
// DONE state in which ready is raised.
//
// Parameters:
//   ADDR_BASE  byte address that maps onto SRAM word 0
//   SRAM_AW    SRAM half-word address width
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   bus        pipeline bus (sram_controller_if.slave)
//   SRAM_DQ    bidirectional SRAM data, driven only while writing
//   SRAM_ADDR  half-word address {word_index, phase}
//   SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N
//              active-low SRAM strobes
//
// Configuration macro:
//   SRAM_WAIT_STATE_EN  when defined, LOW and HIGH each last two cycles with
//                       the strobes held stable and read data captured on the
//                       second cycle. When undefined each phase is one cycle
//                       and no wait counter exists.
// -----------------------------------------------------------------------------
module sram_controller #(
  parameter logic [31:0] ADDR_BASE = 32'd1024,
  parameter int          SRAM_AW   = 18
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int IW = SRAM_AW - 1;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q,   idx_d;     // captured word index
  logic [31:0]    wdata_q, wdata_d;   // captured store data
  logic           is_wr_q, is_wr_d;   // captured operation (1 = store)
  logic [15:0]    low_q,   low_d;     // low half of a load in flight
  logic [31:0]    rdata_q, rdata_d;   // visible load result

  logic           req;
  logic           ready_c;
  logic           phase_last;         // current cycle is the last of its phase
  logic [31:0]    word_off;
  logic [IW-1:0]  word_idx;
  logic           active;
  logic           drive_en;
  logic [15:0]    dq_out;

  // Offset arithmetic wraps modulo 2^32; the index is simply truncated, so
  // out-of-range addresses alias onto the SRAM instead of raising an error.
  assign word_off = (bus.address - ADDR_BASE) >> 2;
  assign word_idx = word_off[IW-1:0];

  logic unused_off_bits;
  assign unused_off_bits = ^word_off[31:IW];

  assign req = bus.wr_en | bus.rd_en;

`ifdef SRAM_WAIT_STATE_EN
  // One-bit wait counter: 0 on the first cycle of a phase, 1 on the second.
  logic wait_q, wait_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
    end
  end

  always_comb begin
    wait_d = 1'b0;
    if (state_q == S_LOW || state_q == S_HIGH) begin
      // Toggling returns the counter to 0 exactly when the phase ends.
      wait_d = ~wait_q;
    end
  end

  assign phase_last = wait_q;
`else
  assign phase_last = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // State and capture registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      low_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      low_q   <= low_d;
      rdata_q <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    low_d   = low_q;
    rdata_d = rdata_q;
    ready_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_c = ~req;
        if (req) begin
          state_d = S_LOW;
          idx_d   = word_idx;
          wdata_d = bus.write_data;
          // A simultaneous store and load is treated as a store only.
          is_wr_d = bus.wr_en;
        end
      end

      S_LOW: begin
        if (phase_last) begin
          state_d = S_HIGH;
          if (!is_wr_q) begin
            low_d = SRAM_DQ;
          end
        end
      end

      S_HIGH: begin
        if (phase_last) begin
          state_d = S_DONE;
          // The low half waits in low_q so the visible result only changes
          // when the whole word is complete.
          if (!is_wr_q) begin
            rdata_d = {SRAM_DQ, low_q};
          end
        end
      end

      S_DONE: begin
        ready_c = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // SRAM pin drive, decoded from the registered state so the pins return to
  // their idle levels as soon as reset asserts.
  // ---------------------------------------------------------------------------
  assign active    = (state_q == S_LOW) || (state_q == S_HIGH);
  assign drive_en  = active & is_wr_q;
  assign dq_out    = (state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0];

  assign SRAM_ADDR = {idx_q, (state_q == S_HIGH)};
  assign SRAM_CE_N = ~active;
  assign SRAM_UB_N = ~active;
  assign SRAM_LB_N = ~active;
  assign SRAM_WE_N = ~drive_en;
  assign SRAM_OE_N = ~(active & ~is_wr_q);
  assign SRAM_DQ   = drive_en ? dq_out : 16'hzzzz;

  assign bus.ready     = ready_c;
  assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//
// Drives sram_controller through a table of directed loads/stores, a few
// multi-cycle sequences (back-to-back, reset mid-access) and a randomized run.
// A half-word SRAM model sits on the pins; expected results come from a
// word-level reference memory indexed by the address arithmetic.
// -----------------------------------------------------------------------------
module tb_sram_controller;
  localparam int AW = 18;
`ifdef SRAM_WAIT_STATE_EN
  localparam int PH = 2;
`else
  localparam int PH = 1;
`endif
  localparam int LAT = 1 + 2 * PH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_controller_if bus();

  wire  [15:0]   sram_dq;
  logic [AW-1:0] sram_addr;
  logic          we_n, oe_n, ce_n, ub_n, lb_n;

  sram_controller #(.ADDR_BASE(32'd1024), .SRAM_AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (we_n),
    .SRAM_OE_N (oe_n),
    .SRAM_CE_N (ce_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n)
  );

  // ---------------- SRAM model ----------------
  logic [15:0] mem [0:(1<<AW)-1];
  logic        probe_en;
  logic [15:0] probe_val;

  assign sram_dq = probe_en ? probe_val :
                   ((!oe_n && !ce_n) ? mem[sram_addr] : 16'hzzzz);

  typedef struct {
    logic [AW-1:0] addr;
    logic          we_n;
    logic          oe_n;
    logic          ub_n;
    logic          lb_n;
    logic [15:0]   dq;
  } log_t;

  log_t log_q[$];
  int   access_cnt;

  initial begin
    logic prev_ce;
    log_t e;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0;
    prev_ce    = 1'b1;
    access_cnt = 0;
    forever begin
      @(negedge clk);
      if (!ce_n) begin
        e.addr = sram_addr; e.we_n = we_n; e.oe_n = oe_n;
        e.ub_n = ub_n; e.lb_n = lb_n; e.dq = sram_dq;
        log_q.push_back(e);
        if (prev_ce) access_cnt++;
        if (!we_n) mem[sram_addr] = sram_dq;
      end
      prev_ce = ce_n;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] ref_rdata;

  function automatic int unsigned ref_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return (off / 4) % (1 << (AW - 1));
  endfunction

  function automatic logic [31:0] ref_read(input int unsigned idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int txn   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_idle_pins(input string name);
    check(name, {27'd0, ce_n, we_n, oe_n, ub_n, lb_n}, 32'h1F);
  endtask

  task automatic check_dq_released(input string name);
    probe_en  = 1'b1;
    probe_val = 16'h1234;
    #1;
    check(name, {16'd0, sram_dq}, 32'h1234);
    probe_val = 16'hC3A5;
    #1;
    check(name, {16'd0, sram_dq}, 32'hC3A5);
    probe_en = 1'b0;
  endtask

  // Called just after a rising edge with the DUT idle. Returns in the DONE
  // cycle with the request still applied (inputs scrambled, enables held).
  task automatic run_access(input bit wr, input bit rd,
                            input logic [31:0] addr, input logic [31:0] wdata);
    int          cyc;
    int          start;
    int          n;
    int unsigned idx;
    bit          ok;
    log_t        e;
    logic [AW-1:0] exp_a;
    logic [15:0] exp_dq;

    start          = log_q.size();
    bus.wr_en      = wr;
    bus.rd_en      = rd;
    bus.address    = addr;
    bus.write_data = wdata;
    #1;
    check("ready_on_request", {31'd0, bus.ready}, 32'd0);

    idx = ref_idx(addr);
    if (wr) ref_mem[idx] = wdata;
    else if (rd) ref_rdata = ref_read(idx);

    @(posedge clk); #1;
    cyc = 1;
    // Request has been sampled; these changes must be ignored.
    bus.address    = $urandom;
    bus.write_data = $urandom;
    while (!bus.ready && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, LAT);
    check("read_data", bus.read_data, ref_rdata);

    ok = 1'b1;
    n  = log_q.size() - start;
    if (n != 2 * PH) begin
      ok = 1'b0;
    end else begin
      for (int i = 0; i < 2 * PH; i++) begin
        e      = log_q[start + i];
        exp_a  = AW'(idx * 2 + i / PH);
        exp_dq = (i / PH == 1) ? wdata[31:16] : wdata[15:0];
        if (e.addr != exp_a || e.we_n != !wr || e.oe_n != wr || e.ub_n || e.lb_n) ok = 1'b0;
        if (wr && e.dq != exp_dq) ok = 1'b0;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL sram_seq txn %0d: got %0d phase cycles, required %0d at half-words %h/%h",
               txn, n, 2 * PH, AW'(idx * 2), AW'(idx * 2 + 1));
    end
    $display("txn %0d wr=%0d rd=%0d addr=%h wdata=%h read_data=%h cycles=%0d",
             txn, wr, rd, addr, wdata, bus.read_data, cyc);
    txn++;
  endtask

  task automatic finish_idle();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    @(posedge clk); #1;
    check("ready_idle", {31'd0, bus.ready}, 32'd1);
    check_idle_pins("idle_pins");
    check("read_data_hold", bus.read_data, ref_rdata);
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vec [11];

  initial begin
    int s0;
    vec[0]  = '{1'b1, 1'b0, 32'd1028,   32'hDEADBEEF, 32'h00000000};
    vec[1]  = '{1'b0, 1'b1, 32'd1028,   32'h0,        32'hDEADBEEF};
    vec[2]  = '{1'b1, 1'b0, 32'd1032,   32'h12345678, 32'hDEADBEEF};
    vec[3]  = '{1'b0, 1'b1, 32'd1032,   32'h0,        32'h12345678};
    vec[4]  = '{1'b0, 1'b1, 32'd1028,   32'h0,        32'hDEADBEEF};
    vec[5]  = '{1'b1, 1'b1, 32'd1024,   32'hCAFEF00D, 32'hDEADBEEF};
    vec[6]  = '{1'b0, 1'b1, 32'd1024,   32'h0,        32'hCAFEF00D};
    vec[7]  = '{1'b1, 1'b0, 32'd1020,   32'hA5A55A5A, 32'hCAFEF00D};
    vec[8]  = '{1'b0, 1'b1, 32'd1020,   32'h0,        32'hA5A55A5A};
    vec[9]  = '{1'b0, 1'b1, 32'd525312, 32'h0,        32'hCAFEF00D};
    vec[10] = '{1'b0, 1'b1, 32'd1023,   32'h0,        32'hA5A55A5A};

    ref_rdata      = 32'h0;
    probe_en       = 1'b0;
    probe_val      = 16'h0;
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.address    = 32'h0;
    bus.write_data = 32'h0;
    rst            = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check_idle_pins("rst_pins");
    check("rst_read_data", bus.read_data, 32'h0);
    check_dq_released("rst_dq_z");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      run_access(vec[i].wr, vec[i].rd, vec[i].addr, vec[i].wdata);
      check("vec_read_data", bus.read_data, vec[i].exp_rd);
      finish_idle();
    end
    check("mem_2", {16'd0, mem[2]}, 32'h0000BEEF);
    check("mem_3", {16'd0, mem[3]}, 32'h0000DEAD);
    check("mem_0", {16'd0, mem[0]}, 32'h0000F00D);
    check("mem_1", {16'd0, mem[1]}, 32'h0000CAFE);
    check("mem_top_lo", {16'd0, mem[(1<<AW)-2]}, 32'h00005A5A);
    check("mem_top_hi", {16'd0, mem[(1<<AW)-1]}, 32'h0000A5A5);
    repeat (3) @(posedge clk);
    #1;
    check("read_data_hold_long", bus.read_data, 32'hA5A55A5A);

    // Back-to-back: load held through DONE with a new address
    s0 = access_cnt;
    run_access(1'b0, 1'b1, 32'd1028, 32'h0);
    bus.address = 32'd1032;
    @(posedge clk); #1;
    run_access(1'b0, 1'b1, 32'd1032, 32'h0);
    check("b2b_read_data", bus.read_data, 32'h12345678);
    finish_idle();
    repeat (4) @(posedge clk);
    #1;
    check("b2b_access_count", access_cnt - s0, 2);

    // Reset in the middle of a load's HIGH phase
    s0 = access_cnt;
    bus.rd_en   = 1'b1;
    bus.address = 32'd1032;
    repeat (1 + PH) begin @(posedge clk); #1; end
    check("pre_rst_in_high", {31'd0, sram_addr[0]}, 32'd1);
    #2;
    rst       = 1'b1;
    bus.rd_en = 1'b0;
    #1;
    check("midrst_ready", {31'd0, bus.ready}, 32'd1);
    check_idle_pins("midrst_pins");
    check("midrst_read_data", bus.read_data, 32'h0);
    check_dq_released("midrst_dq_z");
    ref_rdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_resume", access_cnt - s0, 1);
    check_idle_pins("midrst_idle_pins");

    // Reset in the middle of a store's HIGH phase: only the low half lands
    s0 = access_cnt;
    bus.wr_en      = 1'b1;
    bus.address    = 32'd1040;
    bus.write_data = 32'h11112222;
    repeat (1 + PH) begin @(posedge clk); #1; end
    #2;
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    #1;
    check_idle_pins("wrst_pins");
    check_dq_released("wrst_dq_z");
    ref_mem[ref_idx(32'd1040)] = (ref_read(ref_idx(32'd1040)) & 32'hFFFF0000) | 32'h2222;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("wrst_no_resume", access_cnt - s0, 1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'd1024 + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
      run_access(op == 0 || op == 2, op != 0, a, $urandom);
      if ($urandom_range(0, 1) == 1) begin
        finish_idle();
      end else begin
        @(posedge clk); #1;
      end
    end
    finish_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter ADDR_BASE, default 1024, byte address mapped to SRAM word 0.
REQ-002 Parameter SRAM_AW, default 18, SRAM half-word address width.
REQ-003 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_en  input  1  MEM-stage store request, level-held until ready.
REQ-006 rd_en  input  1  MEM-stage load request, level-held until ready.
REQ-007 address  input  32  byte address from EXE/MEM register.
REQ-008 write_data  input  32  store data (Val_Rm).
REQ-009 read_data  output  32  registered load result.
REQ-010 ready  output  1  access complete / no access pending; pipeline freeze = ~ready.
REQ-011 SRAM_DQ  inout  16  SRAM data bus; driven only during write phases, else high-Z.
REQ-012 SRAM_ADDR  output  SRAM_AW  half-word address.
REQ-013 SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  active-low SRAM controls.

Function
REQ-014 Word index = (address - ADDR_BASE) >> 2, modulo 2^32, truncated to SRAM_AW-1 bits; no range error raised.
REQ-015 SRAM_ADDR = {word_index, 0} in LOW phase, {word_index, 1} in HIGH phase; 32-bit word is little-endian: low half at even address.
REQ-016 FSM states IDLE, LOW, HIGH, DONE; IDLE->LOW when (wr_en|rd_en); LOW->HIGH; HIGH->DONE; DONE->IDLE unconditionally.
REQ-017 Request sampled (address, write_data, op) into internal registers on IDLE->LOW edge; later input changes ignored until DONE.
REQ-018 wr_en and rd_en both high: write wins, no read performed, read_data unchanged.
REQ-019 ready = 1 in IDLE with no request and in DONE; 0 in IDLE with request, LOW, HIGH.
REQ-020 Latency: request first seen in IDLE at cycle N -> ready=1 during cycle N+3 (macro off).
REQ-021 Read: SRAM_OE_N=0, SRAM_WE_N=1 in LOW/HIGH; read_data[15:0] captured end of LOW, read_data[31:16] end of HIGH.
REQ-022 read_data holds last completed load value until the next load completes; stores never change it.
REQ-023 Write: SRAM_WE_N=0, SRAM_OE_N=1, SRAM_DQ driven with write_data[15:0] in LOW, [31:16] in HIGH.
REQ-024 SRAM_CE_N, SRAM_UB_N, SRAM_LB_N = 0 in LOW/HIGH, 1 in IDLE/DONE; WE_N=OE_N=1 in IDLE/DONE.
REQ-025 DONE lasts exactly one cycle so a held request is not re-issued; a request present in IDLE after DONE starts a new access.

Reset
REQ-026 rst=1 forces state IDLE, read_data=0, captured registers=0, all SRAM controls=1, SRAM_DQ high-Z, immediately without clock.
REQ-027 Reset mid-access aborts it; partial write may remain in SRAM; no access resumes after release unless a request is present in IDLE.

Configuration
REQ-028 Macro SRAM_WAIT_STATE_EN defined: LOW and HIGH each last 2 cycles (controls stable both cycles, capture on second), ready at N+5.
REQ-029 Macro undefined: each phase lasts 1 cycle, ready at N+3, no wait counter synthesized.

Verification
REQ-030 Reset: rst pulse mid-HIGH -> ready=1 in IDLE state, controls=1, DQ high-Z, read_data=0 same cycle.
REQ-031 Store: wr_en, address=1028, write_data=0xDEADBEEF -> SRAM_ADDR=2 data 0xBEEF, then 3 data 0xDEAD, WE_N low both, ready at N+3.
REQ-032 Load: model SRAM holds 0xBEEF@2, 0xDEAD@3; rd_en, address=1028 -> read_data=0xDEADBEEF, ready at N+3, held after rd_en drops.
REQ-033 Back-to-back: rd_en held across DONE with new address 1032 -> second access starts cycle after DONE, exactly two accesses issued.
REQ-034 Conflict: wr_en=rd_en=1, address=1024 -> write to halves 0/1 only, read_data unchanged.
REQ-035 SRAM_WAIT_STATE_EN defined: REQ-031 stimulus -> each half presented 2 cycles, ready at N+5.
